inst_fetch_unit: RTL

//  Instruction-fetch initiator for the pipelined CPU; drives the instruction-memory read port (memread/addr/readdata).

---
 rtl/inst_fetch_unit.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/inst_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : inst_fetch_unit
// Description : Instruction-fetch initiator for the pipelined CPU.
//               Holds the PC, issues word-aligned reads to the instruction
//               memory, waits a fixed memory latency, and buffers returned
//               words in a small prefetch FIFO. The FIFO head is presented
//               to decode with valid/stall flow control. A branch/jump
//               redirect flushes the FIFO and restarts fetching.
//
// Ports       : clk            rising-edge clock
//               rst_n          asynchronous active-low reset
//               o_memread      read enable to instruction memory (registered)
//               o_addr         byte address to instruction memory (registered)
//               i_readdata     instruction word from memory
//               i_stall        decode cannot accept this cycle
//               i_redirect     branch/jump taken; restart fetch
//               i_redirect_pc  new fetch address (low 2 bits ignored)
//               o_instr        FIFO head instruction (holds last when empty)
//               o_instr_pc     byte address of o_instr
//               o_instr_valid  FIFO non-empty
//               o_q_count      FIFO occupancy
//
// Revision    : 1.0  initial release
// ============================================================================
module inst_fetch_unit #(
   parameter int                ADDR_W   = 8,
   parameter int                DATA_W   = 32,
   parameter int                MEM_LAT  = 2,
   parameter int                QDEPTH   = 2,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   localparam int               CNT_W    = $clog2(QDEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              o_memread,
   output logic [ADDR_W-1:0] o_addr,
   input  logic [DATA_W-1:0] i_readdata,
   input  logic              i_stall,
   input  logic              i_redirect,
   input  logic [ADDR_W-1:0] i_redirect_pc,
   output logic [DATA_W-1:0] o_instr,
   output logic [ADDR_W-1:0] o_instr_pc,
   output logic              o_instr_valid,
   output logic [CNT_W-1:0]  o_q_count
);

   // ------------------------------------------------------------------------
   // Constants
   // ------------------------------------------------------------------------
   localparam int PTR_W = $clog2(QDEPTH);
   localparam int LAT_W = $clog2(MEM_LAT + 1);

   localparam logic [1:0]        c_ISSUE = 2'd0;
   localparam logic [1:0]        c_WAIT  = 2'd1;
   localparam logic [1:0]        c_HOLD  = 2'd2;

   localparam logic [LAT_W-1:0]  c_LAT_LAST   = LAT_W'(MEM_LAT);
   localparam logic [LAT_W-1:0]  c_LAT_FIRST  = LAT_W'(1);
   localparam logic [CNT_W-1:0]  c_CNT_FULL   = CNT_W'(QDEPTH);
   localparam logic [PTR_W-1:0]  c_PTR_ONE    = PTR_W'(1);
   localparam logic [ADDR_W-1:0] c_PC_STEP    = ADDR_W'(4);
   localparam logic [ADDR_W-1:0] c_ALIGN_MASK = ~(ADDR_W'(3));

   // ------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------
   logic [1:0]        r_state;
   logic [ADDR_W-1:0] r_pc;
   logic [LAT_W-1:0]  r_lat_cnt;
   logic              r_memread;
   logic [ADDR_W-1:0] r_addr;

   logic [DATA_W-1:0] r_q_data [QDEPTH];
   logic [ADDR_W-1:0] r_q_pc   [QDEPTH];
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [CNT_W-1:0]  r_count;

   logic [DATA_W-1:0] r_instr;
   logic [ADDR_W-1:0] r_instr_pc;
   logic              r_instr_valid;

   // ------------------------------------------------------------------------
   // Combinational control
   // ------------------------------------------------------------------------
   logic              w_pop;
   logic              w_push;
   logic              w_full;
   logic              w_room;
   logic [PTR_W-1:0]  w_rd_ptr_nxt;
   logic [PTR_W-1:0]  w_wr_ptr_nxt;
   logic [CNT_W-1:0]  w_count_nxt;
   logic              w_head_from_push;

   always_comb begin
      // A redirect flushes everything, so a coincident pop is not honoured.
      w_pop  = r_instr_valid && !i_stall && !i_redirect;
      w_full = (r_count == c_CNT_FULL);
      // A slot freed by this cycle's pop counts as room.
      w_room = !w_full || w_pop;
      // In-flight data is discarded on redirect, never pushed.
      w_push = (r_state == c_WAIT) && (r_lat_cnt == c_LAT_LAST) && !i_redirect;

      w_rd_ptr_nxt = r_rd_ptr;
      w_wr_ptr_nxt = r_wr_ptr;
      w_count_nxt  = r_count;
      if (i_redirect) begin
         w_rd_ptr_nxt = '0;
         w_wr_ptr_nxt = '0;
         w_count_nxt  = '0;
      end else begin
         if (w_pop) begin
            w_rd_ptr_nxt = r_rd_ptr + c_PTR_ONE;
         end
         if (w_push) begin
            w_wr_ptr_nxt = r_wr_ptr + c_PTR_ONE;
         end
         w_count_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      end

      // The pushed word becomes the new head only when it lands in the slot
      // the read pointer will point at, i.e. the FIFO is empty after the pop.
      w_head_from_push = w_push && (w_rd_ptr_nxt == r_wr_ptr);
   end

   // ------------------------------------------------------------------------
   // Fetch FSM: ISSUE -> WAIT (MEM_LAT cycles) -> ISSUE, or ISSUE -> HOLD
   // while the FIFO is full.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= c_ISSUE;
         r_pc      <= RESET_PC & c_ALIGN_MASK;
         r_addr    <= RESET_PC & c_ALIGN_MASK;
         r_memread <= 1'b0;
         r_lat_cnt <= '0;
      end else if (i_redirect) begin
         r_state   <= c_ISSUE;
         r_pc      <= i_redirect_pc & c_ALIGN_MASK;
         r_memread <= 1'b0;
         r_lat_cnt <= '0;
      end else begin
         case (r_state)
            c_ISSUE: begin
               if (w_room) begin
                  r_addr    <= r_pc;
                  r_memread <= 1'b1;
                  r_lat_cnt <= c_LAT_FIRST;
                  r_state   <= c_WAIT;
               end else begin
                  r_memread <= 1'b0;
                  r_state   <= c_HOLD;
               end
            end
            c_WAIT: begin
               if (r_lat_cnt == c_LAT_LAST) begin
                  r_memread <= 1'b0;
                  r_pc      <= r_pc + c_PC_STEP;
                  r_lat_cnt <= '0;
                  r_state   <= c_ISSUE;
               end else begin
                  r_lat_cnt <= r_lat_cnt + c_LAT_FIRST;
               end
            end
            c_HOLD: begin
               r_memread <= 1'b0;
               if (w_room) begin
                  r_state <= c_ISSUE;
               end
            end
            default: begin
               r_memread <= 1'b0;
               r_lat_cnt <= '0;
               r_state   <= c_ISSUE;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // FIFO storage (data path only, no reset needed: occupancy guards reads)
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_q_data[r_wr_ptr] <= i_readdata;
         r_q_pc[r_wr_ptr]   <= r_addr;
      end
   end

   // ------------------------------------------------------------------------
   // FIFO pointers, occupancy and registered head outputs
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_ptr      <= '0;
         r_wr_ptr      <= '0;
         r_count       <= '0;
         r_instr_valid <= 1'b0;
         r_instr       <= '0;
         r_instr_pc    <= '0;
      end else begin
         r_rd_ptr      <= w_rd_ptr_nxt;
         r_wr_ptr      <= w_wr_ptr_nxt;
         r_count       <= w_count_nxt;
         r_instr_valid <= (w_count_nxt != '0);
         // Head registers track the next-cycle head; when the FIFO goes
         // empty they simply hold the last value.
         if (w_count_nxt != '0) begin
            if (w_head_from_push) begin
               r_instr    <= i_readdata;
               r_instr_pc <= r_addr;
            end else begin
               r_instr    <= r_q_data[w_rd_ptr_nxt];
               r_instr_pc <= r_q_pc[w_rd_ptr_nxt];
            end
         end
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign o_memread     = r_memread;
   assign o_addr        = r_addr;
   assign o_instr       = r_instr;
   assign o_instr_pc    = r_instr_pc;
   assign o_instr_valid = r_instr_valid;
   assign o_q_count     = r_count;

endmodule
`default_nettype wire
